cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 170 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Instruction-phase sequencer: eight phases per instruction, with free-run and
// single-step execution and an HLT latch that only step or reset releases.
module cpu_sequencer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 step,
  input  logic [2:0]           opcode,
  input  logic                 zero,
  output logic                 sel,
  output logic                 rd,
  output logic                 wr,
  output logic                 ld_ir,
  output logic                 ld_ac,
  output logic                 ld_pc,
  output logic                 inc_pc,
  output logic                 halt,
  output logic                 data_e,
  output logic [2:0]           phase,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    HALTED  = 1'b0,
    RUNNING = 1'b1
  } mode_e;

  mode_e                mode_q, mode_d;
  logic [2:0]           phase_q, phase_d;
  logic                 step_q, step_d;
  logic                 hlt_q, hlt_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic go;
  logic retire;
  logic is_alu;
  logic is_hlt;
  logic is_skz;
  logic is_sto;
  logic is_jmp;

  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

  // A latched HLT blocks run-only restarts; step always gets through.
  assign go     = step | (run & ~hlt_q);
  assign retire = (mode_q == RUNNING) && (phase_q == 3'd7);

  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    step_d  = step_q;
    hlt_d   = hlt_q;
    cnt_d   = cnt_q;
    case (mode_q)
      HALTED: begin
        phase_d = 3'd0;
        if (go) begin
          mode_d = RUNNING;
          step_d = step;
          if (step) begin
            hlt_d = 1'b0;
          end
        end
      end
      RUNNING: begin
        phase_d = phase_q + 3'd1;
        if (retire) begin
          cnt_d = cnt_q + CNT_ONE;
          if (is_hlt || step_q || !run) begin
            mode_d = HALTED;
            if (is_hlt) begin
              hlt_d = 1'b1;
            end
          end
        end
      end
      default: begin
        mode_d  = HALTED;
        phase_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= HALTED;
      phase_q <= 3'd0;
      step_q  <= 1'b0;
      hlt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      hlt_q   <= hlt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode straight off the registered phase so they line up with it.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    data_e = 1'b0;
    if (mode_q == RUNNING) begin
      case (phase_q)
        3'd0: sel = 1'b1;
        3'd1: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        3'd2, 3'd3: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        3'd4: begin
          inc_pc = 1'b1;
          halt   = is_hlt;
        end
        3'd5: rd = is_alu;
        3'd6: begin
          rd     = is_alu;
          inc_pc = is_skz & zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        3'd7: begin
          rd     = is_alu;
          ld_ac  = is_alu;
          ld_pc  = is_jmp;
          inc_pc = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: sel = 1'b0;
      endcase
    end
  end

  assign phase       = phase_q;
  assign halted      = (mode_q == HALTED);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus random traffic, every cycle
// compared against a phase-table model; a second instance checks a 4-bit counter.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [2:0]  opcode = 3'd0;
  logic        zero = 1'b0;

  logic        sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e;
  logic [2:0]  phase;
  logic        halted;
  logic [15:0] instr_count;

  logic        s4_sel, s4_rd, s4_wr, s4_ld_ir, s4_ld_ac, s4_ld_pc, s4_inc_pc;
  logic        s4_halt, s4_data_e, s4_halted;
  logic [2:0]  s4_phase;
  logic [3:0]  s4_count;

  cpu_sequencer #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac), .ld_pc(ld_pc),
    .inc_pc(inc_pc), .halt(halt), .data_e(data_e), .phase(phase),
    .halted(halted), .instr_count(instr_count)
  );

  cpu_sequencer #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .run(run), .step(step), .opcode(opcode), .zero(zero),
    .sel(s4_sel), .rd(s4_rd), .wr(s4_wr), .ld_ir(s4_ld_ir), .ld_ac(s4_ld_ac),
    .ld_pc(s4_ld_pc), .inc_pc(s4_inc_pc), .halt(s4_halt), .data_e(s4_data_e),
    .phase(s4_phase), .halted(s4_halted), .instr_count(s4_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: is an instruction in flight, which phase, and the flags.
  bit          m_busy = 1'b0;
  int          m_ph = 0;
  bit          m_single = 1'b0;
  bit          m_hlt = 1'b0;
  int unsigned m_retired = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected strobe vector {sel,rd,wr,ld_ir,ld_ac,ld_pc,inc_pc,halt,data_e}
  // built from per-signal "active in phases" masks for the current opcode.
  function automatic logic [8:0] exp_strobes();
    bit [7:0] sel_m, rd_m, wr_m, ir_m, ac_m, pc_m, inc_m, hlt_m, de_m;
    bit alu;
    logic [8:0] v;
    alu   = (opcode >= 3'd2) && (opcode <= 3'd5);
    sel_m = 8'b0000_1111;
    rd_m  = 8'b0000_1110 | (alu ? 8'b1110_0000 : 8'h00);
    ir_m  = 8'b0000_1100;
    ac_m  = alu ? 8'b1000_0000 : 8'h00;
    inc_m = 8'b0001_0000 | ((opcode == 3'd1 && zero) ? 8'b0100_0000 : 8'h00)
                         | ((opcode == 3'd7) ? 8'b1000_0000 : 8'h00);
    pc_m  = (opcode == 3'd7) ? 8'b1100_0000 : 8'h00;
    wr_m  = (opcode == 3'd6) ? 8'b1000_0000 : 8'h00;
    de_m  = (opcode == 3'd6) ? 8'b1100_0000 : 8'h00;
    hlt_m = (opcode == 3'd0) ? 8'b0001_0000 : 8'h00;
    if (!m_busy) return 9'd0;
    v = {sel_m[m_ph], rd_m[m_ph], wr_m[m_ph], ir_m[m_ph], ac_m[m_ph],
         pc_m[m_ph], inc_m[m_ph], hlt_m[m_ph], de_m[m_ph]};
    return v;
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    if (rst) begin
      m_busy = 0; m_ph = 0; m_single = 0; m_hlt = 0; m_retired = 0;
    end else if (!m_busy) begin
      if (step) begin
        m_busy = 1; m_ph = 0; m_single = 1; m_hlt = 0;
      end else if (run && !m_hlt) begin
        m_busy = 1; m_ph = 0; m_single = 0;
      end
    end else if (m_ph == 7) begin
      m_retired++;
      m_ph = 0;
      if (opcode == 3'd0 || m_single || !run) begin
        m_busy = 0;
        if (opcode == 3'd0) m_hlt = 1;
      end
    end else begin
      m_ph++;
    end
  endtask

  task automatic cycle(input bit r, input bit ru, input bit st, input logic [2:0] op, input bit z);
    rst = r; run = ru; step = st; opcode = op; zero = z;
    @(negedge clk);
    check_val("strobes", {23'd0, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e},
              {23'd0, exp_strobes()});
    check_val("strobes_w4", {23'd0, s4_sel, s4_rd, s4_wr, s4_ld_ir, s4_ld_ac, s4_ld_pc,
              s4_inc_pc, s4_halt, s4_data_e}, {23'd0, exp_strobes()});
    check_val("phase", {29'd0, phase}, m_busy ? m_ph : 0);
    check_val("halted", {31'd0, halted}, {31'd0, !m_busy});
    check_val("count16", {16'd0, instr_count}, m_retired & 32'hFFFF);
    check_val("count4", {28'd0, s4_count}, m_retired & 32'hF);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_seq(input bit ru);
    cycle(1, ru, 0, 3'd5, 0);
    cycle(1, ru, 0, 3'd5, 0);
  endtask

  initial begin
    // Reset with run high, then a free-running LDA.
    reset_seq(1);
    for (int i = 0; i < 10; i++) cycle(0, 1, 0, 3'd5, 0);
    check_val("lda_retired", {16'd0, instr_count}, 32'd1);
    check_val("lda_no_gap_phase", {29'd0, phase}, 32'd1);

    // SKZ with zero high and low, JMP, STO back to back.
    reset_seq(0);
    cycle(0, 1, 0, 3'd1, 1);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 3'd1, 1);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 3'd1, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 3'd7, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 3'd6, 0);

    // HLT latches; run alone cannot restart; one step runs one instruction.
    reset_seq(0);
    for (int i = 0; i < 9; i++) cycle(0, 1, 0, 3'd0, 0);
    for (int i = 0; i < 22; i++) cycle(0, 1, 0, 3'd2, 0);
    check_val("hlt_stays_halted", {31'd0, halted}, 32'd1);
    check_val("hlt_count", {16'd0, instr_count}, 32'd1);
    cycle(0, 0, 1, 3'd2, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 3'd2, 0);
    check_val("step_halted", {31'd0, halted}, 32'd1);
    check_val("step_count", {16'd0, instr_count}, 32'd2);
    // Step during a run must be ignored, step+run in halted acts as step.
    cycle(0, 1, 1, 3'd3, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, i == 3, 3'd3, 0);
    check_val("step_run_single", {31'd0, halted}, 32'd1);

    // run dropped during phase 2 still completes the instruction.
    reset_seq(0);
    cycle(0, 1, 0, 3'd2, 0);
    cycle(0, 1, 0, 3'd2, 0);
    cycle(0, 1, 0, 3'd2, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 3'd2, 0);
    check_val("rundrop_halted", {31'd0, halted}, 32'd1);
    check_val("rundrop_phase", {29'd0, phase}, 32'd0);
    check_val("rundrop_count", {16'd0, instr_count}, 32'd1);

    // Reset in phase 5 of an ADD aborts without retirement.
    reset_seq(0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 3'd2, 0);
    cycle(1, 1, 0, 3'd2, 0);
    check_val("abort_halted", {31'd0, halted}, 32'd1);
    check_val("abort_phase", {29'd0, phase}, 32'd0);
    check_val("abort_count", {16'd0, instr_count}, 32'd0);
    check_val("abort_ld_ac", {31'd0, ld_ac}, 32'd0);

    // Sixteen retirements wrap the 4-bit counter.
    reset_seq(0);
    for (int i = 0; i < 1 + 16 * 8; i++) cycle(0, 1, 0, 3'd4, 0);
    check_val("wrap_count4", {28'd0, s4_count}, 32'd0);
    check_val("wrap_count16", {16'd0, instr_count}, 32'd16);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0,
            $urandom_range(0, 11) == 0, 3'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
